// File: rtl/envelope_pkg.sv
// Shared types and helpers for the envelope noise gate.
// Gate state encoding plus the unity-gain helper.
package envelope_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } gate_state_t;

    function automatic int gain_unity(input int gain_width);
        return 1 << gain_width;
    endfunction

endpackage

// File: rtl/envelope_gate_gain_apply.sv
// Applies the unsigned fixed-point gain to signed audio.
// One-sample registered latency.
module gain_apply #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 16
) (
    input  logic                           sample_clock,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] audio_in,
    input  logic        [GAIN_WIDTH:0]     gain,
    output logic signed [SAMPLE_WIDTH-1:0] audio_out
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 2;

    logic signed [PROD_WIDTH-1:0] audio_ext;
    logic signed [PROD_WIDTH-1:0] gain_ext;

    assign audio_ext = PROD_WIDTH'(audio_in);
    assign gain_ext  = $signed(PROD_WIDTH'({1'b0, gain}));

    // gain never exceeds unity, so the shifted product always fits
    always_ff @(posedge sample_clock) begin
        if (rst) begin
            audio_out <= '0;
        end else begin
            audio_out <= SAMPLE_WIDTH'((audio_ext * gain_ext) >>> GAIN_WIDTH);
        end
    end

endmodule

// File: rtl/envelope_gate.sv
// Hysteresis noise gate: attack/hold/release FSM with gain ramp,
// gain applied to the time-aligned audio sample.
import envelope_pkg::*;

module envelope_gate #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 16,
    parameter int HOLD_WIDTH   = 16
) (
    input  logic                    sample_clock,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] env_in,
    input  logic [SAMPLE_WIDTH-1:0] audio_in,
    input  logic [SAMPLE_WIDTH-1:0] open_thresh,
    input  logic [SAMPLE_WIDTH-1:0] close_thresh,
    input  logic [HOLD_WIDTH-1:0]   hold_len,
    input  logic [GAIN_WIDTH:0]     attack_step,
    input  logic [GAIN_WIDTH:0]     release_step,
    output logic [SAMPLE_WIDTH-1:0] audio_out,
    output logic [GAIN_WIDTH:0]     gain,
    output logic                    gate_open,
    output logic [2:0]              state
);

    localparam logic [GAIN_WIDTH:0] UNITY =
        (GAIN_WIDTH+1)'(gain_unity(GAIN_WIDTH));

    gate_state_t             cur_state;
    gate_state_t             next_state;
    logic [GAIN_WIDTH:0]     next_gain;
    logic [HOLD_WIDTH-1:0]   hold_cnt;
    logic [HOLD_WIDTH-1:0]   next_hold;
    logic                    next_open;

    logic                    above;
    logic                    below;
    logic [GAIN_WIDTH+1:0]   gain_sum;
    logic [GAIN_WIDTH+1:0]   gain_diff;
    logic [GAIN_WIDTH:0]     ramp_up;
    logic [GAIN_WIDTH:0]     ramp_down;

    // above wins when misconfigured thresholds make both true
    assign above = env_in >= open_thresh;
    assign below = (env_in < close_thresh) && !above;

    // one extra bit catches saturation in both directions
    assign gain_sum  = {1'b0, gain} + {1'b0, attack_step};
    assign gain_diff = {1'b0, gain} - {1'b0, release_step};

    always_comb begin
        ramp_up = gain_sum[GAIN_WIDTH:0];
        if (gain_sum >= {1'b0, UNITY} || attack_step == '0) begin
            ramp_up = UNITY;
        end
    end

    always_comb begin
        ramp_down = gain_diff[GAIN_WIDTH:0];
        if (gain_diff[GAIN_WIDTH+1] || release_step == '0) begin
            ramp_down = '0;
        end
    end

    always_ff @(posedge sample_clock) begin
        if (rst) begin
            cur_state <= ST_CLOSED;
            gain      <= '0;
            hold_cnt  <= '0;
            gate_open <= 1'b0;
        end else begin
            cur_state <= next_state;
            gain      <= next_gain;
            hold_cnt  <= next_hold;
            gate_open <= next_open;
        end
    end

    always_comb begin
        next_state = cur_state;
        next_gain  = gain;
        next_hold  = hold_cnt;
        next_open  = 1'b0;

        case (cur_state)
            ST_CLOSED: begin
                next_gain = '0;
                if (above) begin
                    next_state = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (below) begin
                    next_state = ST_RELEASE;
                end else begin
                    next_gain = ramp_up;
                    if (ramp_up == UNITY) begin
                        next_state = ST_OPEN;
                    end
                end
            end
            ST_OPEN: begin
                next_gain = UNITY;
                if (below) begin
                    if (hold_len == '0) begin
                        next_state = ST_RELEASE;
                    end else begin
                        next_state = ST_HOLD;
                        next_hold  = hold_len;
                    end
                end
            end
            ST_HOLD: begin
                if (above) begin
                    next_state = ST_OPEN;
                end else if (hold_cnt <= 1) begin
                    next_state = ST_RELEASE;
                    next_hold  = '0;
                end else begin
                    next_hold = hold_cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                // retrigger resumes the ramp from the current gain
                if (above) begin
                    next_state = ST_ATTACK;
                end else begin
                    next_gain = ramp_down;
                    if (ramp_down == '0) begin
                        next_state = ST_CLOSED;
                    end
                end
            end
            default: begin
                next_state = ST_CLOSED;
                next_gain  = '0;
                next_hold  = '0;
            end
        endcase

        next_open = (next_state == ST_ATTACK) ||
                    (next_state == ST_OPEN) ||
                    (next_state == ST_HOLD);
    end

    assign state = cur_state;

    gain_apply #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .GAIN_WIDTH   (GAIN_WIDTH)
    ) u_gain_apply (
        .sample_clock (sample_clock),
        .rst          (rst),
        .audio_in     (audio_in),
        .gain         (gain),
        .audio_out    (audio_out)
    );

endmodule

// File: tb/tb_envelope_gate.sv
// Self-checking bench for envelope_gate: directed test-plan steps
// followed by randomized traffic against a behavioural model.
module tb_envelope_gate;

    localparam int UNITY = 65536;
    localparam int M_CLOSED  = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_OPEN    = 2;
    localparam int M_HOLD    = 3;
    localparam int M_RELEASE = 4;

    logic        sample_clock = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] env_in = '0;
    logic [23:0] audio_in = '0;
    logic [23:0] open_thresh = 24'd1000;
    logic [23:0] close_thresh = 24'd500;
    logic [15:0] hold_len = 16'd3;
    logic [16:0] attack_step = 17'd16384;
    logic [16:0] release_step = 17'd32768;
    logic [23:0] audio_out;
    logic [16:0] gain;
    logic        gate_open;
    logic [2:0]  state;

    envelope_gate dut (
        .sample_clock (sample_clock),
        .rst          (rst),
        .env_in       (env_in),
        .audio_in     (audio_in),
        .open_thresh  (open_thresh),
        .close_thresh (close_thresh),
        .hold_len     (hold_len),
        .attack_step  (attack_step),
        .release_step (release_step),
        .audio_out    (audio_out),
        .gain         (gain),
        .gate_open    (gate_open),
        .state        (state)
    );

    always #5 sample_clock = ~sample_clock;

    int          n_assert = 0;
    int          n_fail = 0;
    int          m_state = M_CLOSED;
    int          m_gain = 0;
    int          m_hold = 0;
    logic [23:0] m_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: one sample through the gate rules.
    task automatic tick();
        int     s = m_state;
        int     g = m_gain;
        int     h = m_hold;
        bit     above;
        bit     below;
        longint p;
        logic [23:0] o;
        above = env_in >= open_thresh;
        below = (env_in < close_thresh) && !above;
        p = longint'($signed(audio_in)) * longint'(m_gain);
        o = 24'(p >>> 16);
        if (rst) begin
            s = M_CLOSED; g = 0; h = 0; o = '0;
        end else if (m_state == M_CLOSED) begin
            g = 0;
            if (above) s = M_ATTACK;
        end else if (m_state == M_ATTACK) begin
            if (below) s = M_RELEASE;
            else begin
                g = (attack_step == 0) ? UNITY : m_gain + int'(attack_step);
                if (g > UNITY) g = UNITY;
                if (g == UNITY) s = M_OPEN;
            end
        end else if (m_state == M_OPEN) begin
            if (below) begin
                if (hold_len == 0) s = M_RELEASE;
                else begin s = M_HOLD; h = int'(hold_len); end
            end
        end else if (m_state == M_HOLD) begin
            if (above) s = M_OPEN;
            else if (m_hold == 1) s = M_RELEASE;
            else h = m_hold - 1;
        end else begin
            if (above) s = M_ATTACK;
            else begin
                g = (release_step == 0) ? 0 : m_gain - int'(release_step);
                if (g < 0) g = 0;
                if (g == 0) s = M_CLOSED;
            end
        end
        @(posedge sample_clock);
        #1;
        m_state = s; m_gain = g; m_hold = h; m_out = o;
        chk("state", 64'(state), 64'(m_state));
        chk("gain", 64'(gain), 64'(m_gain));
        chk("gate_open", 64'(gate_open),
            64'(m_state == M_ATTACK || m_state == M_OPEN || m_state == M_HOLD));
        chk("audio_out", 64'(audio_out), 64'(m_out));
    endtask

    initial begin
        // reset with a loud input
        rst = 1'b1;
        audio_in = 24'h100000;
        env_in = 24'hFFFFFF;
        tick();
        tick();
        chk("rst_audio", 64'(audio_out), 64'd0);
        chk("rst_gain", 64'(gain), 64'd0);
        chk("rst_state", 64'(state), 64'(M_CLOSED));
        rst = 1'b0;
        tick();
        chk("rst_exit_attack", 64'(state), 64'(M_ATTACK));

        // attack ramp in quarter steps
        audio_in = 24'd1000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("ramp_gain", 64'(gain), 64'(k * 16384));
        end
        chk("ramp_open", 64'(state), 64'(M_OPEN));
        tick();
        chk("unity_audio", 64'(audio_out), 64'd1000);

        // hold 3 samples then release
        env_in = 24'd100;
        tick();
        chk("hold_entry", 64'(state), 64'(M_HOLD));
        tick();
        tick();
        chk("hold_last", 64'(state), 64'(M_HOLD));
        tick();
        chk("release_entry", 64'(state), 64'(M_RELEASE));
        chk("release_gate", 64'(gate_open), 64'd0);
        tick();
        chk("release_half", 64'(gain), 64'd32768);
        tick();
        chk("release_closed", 64'(state), 64'(M_CLOSED));

        // retrigger during hold and during release
        env_in = 24'hFFFFFF;
        repeat (5) tick();
        env_in = 24'd100;
        tick();
        tick();
        env_in = 24'hFFFFFF;
        tick();
        chk("retrig_hold", 64'(state), 64'(M_OPEN));
        chk("retrig_hold_gain", 64'(gain), 64'(UNITY));
        env_in = 24'd100;
        repeat (5) tick();
        chk("rel_at_half", 64'(gain), 64'd32768);
        env_in = 24'hFFFFFF;
        tick();
        chk("retrig_rel", 64'(state), 64'(M_ATTACK));
        tick();
        chk("retrig_resume", 64'(gain), 64'd49152);
        tick();

        // hysteresis band
        env_in = 24'd700;
        repeat (3) tick();
        chk("hyst_open", 64'(state), 64'(M_OPEN));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("hyst_closed", 64'(state), 64'(M_CLOSED));

        // zero attack step, zero hold, negative rounding
        attack_step = '0;
        env_in = 24'hFFFFFF;
        tick();
        tick();
        chk("atk0_open", 64'(state), 64'(M_OPEN));
        chk("atk0_gain", 64'(gain), 64'(UNITY));
        hold_len = '0;
        env_in = 24'd100;
        tick();
        chk("hold0_release", 64'(state), 64'(M_RELEASE));
        audio_in = 24'hFFFFFF;
        tick();
        tick();
        chk("neg_round", 64'(audio_out), 64'h0000_0000_00FF_FFFF);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            env_in = 24'($urandom_range(0, 1600));
            audio_in = 24'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                open_thresh = 24'($urandom_range(300, 1200));
                close_thresh = 24'($urandom_range(200, 1300));
            end
            attack_step = ($urandom_range(0, 7) == 0) ? 17'd0 :
                          17'($urandom_range(1, 70000));
            release_step = ($urandom_range(0, 7) == 0) ? 17'd0 :
                           17'($urandom_range(1, 70000));
            hold_len = 16'($urandom_range(0, 5));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/envelope_gate.md
# envelope_gate

Envelope-driven noise gate sitting directly downstream of the 8-sample moving-average envelope analyzer. It compares the smoothed envelope against open/close thresholds with hysteresis, runs an attack/hold/release state machine and ramps a gain value. It applies that gain to the time-aligned audio sample, producing the gated audio stream for the output stage.

## Interface
- SAMPLE_WIDTH, 24, width of envelope, audio and threshold words
- GAIN_WIDTH, 16, fractional bits of gain; unity = 2^GAIN_WIDTH
- HOLD_WIDTH, 16, width of hold counter
- sample_clock  in  1  sample clock (96 kHz); single clock domain, all state advances on rising edge
- rst  in  1  synchronous, active-high reset
- env_in  in  SAMPLE_WIDTH  unsigned envelope from envelope analyzer
- audio_in  in  SAMPLE_WIDTH  signed two's-complement audio, aligned to env_in
- open_thresh  in  SAMPLE_WIDTH  unsigned open threshold
- close_thresh  in  SAMPLE_WIDTH  unsigned close threshold
- hold_len  in  HOLD_WIDTH  hold time in samples
- attack_step  in  GAIN_WIDTH+1  gain increment per sample
- release_step  in  GAIN_WIDTH+1  gain decrement per sample
- audio_out  out  SAMPLE_WIDTH  signed gated audio, registered
- gain  out  GAIN_WIDTH+1  current gain, unsigned, 0..UNITY
- gate_open  out  1  high in ATTACK, OPEN, HOLD
- state  out  3  current state encoding

## Operation
- States: CLOSED(0), ATTACK(1), OPEN(2), HOLD(3), RELEASE(4). Decisions use registered state/gain and current env_in.
- "above" = env_in >= open_thresh; "below" = env_in < close_thresh; unsigned compares. Above has priority over below when both true (misconfigured thresholds).
- CLOSED: gain held 0. Above -> ATTACK.
- ATTACK: gain <= min(gain + attack_step, UNITY); when new gain == UNITY -> OPEN. Below (and not above) -> RELEASE, gain unchanged that cycle. attack_step == 0 -> gain <= UNITY, -> OPEN same edge.
- OPEN: gain = UNITY. Below -> HOLD with hold_cnt <= hold_len; if hold_len == 0 -> RELEASE directly.
- HOLD: above -> OPEN (retrigger, counter discarded). Else hold_cnt decrements; at hold_cnt == 1 -> RELEASE. HOLD therefore lasts exactly hold_len samples absent retrigger.
- RELEASE: gain <= max(gain - release_step, 0); when new gain == 0 -> CLOSED. Above -> ATTACK, ramp continues from current gain. release_step == 0 -> gain <= 0, -> CLOSED same edge.
- Arithmetic: product = audio_in (signed) * {1'b0, gain} in SAMPLE_WIDTH+GAIN_WIDTH+2 bits; audio_out = product >>> GAIN_WIDTH, truncated to SAMPLE_WIDTH (no overflow possible since gain <= UNITY). Arithmetic shift rounds toward -inf.
- Gain add/sub computed one bit wider than gain to detect saturation; no wrap permitted.
- Threshold/step/hold inputs sampled every cycle; changes take effect the next edge, mid-ramp included.

## Timing
- Reset (rst high at edge): state CLOSED, gain 0, hold_cnt 0, audio_out 0, gate_open 0. Reset mid-ramp or mid-hold wins unconditionally; first decision on the edge after rst deasserts.
- audio_out at edge n = audio_in present before edge n times gain register value before edge n: 1-sample latency, gain change visible on audio one sample after state change.
- gate_open and state are registered, update same edge as state transition.
- Full-scale ramp: ceil(UNITY/attack_step) samples CLOSED->OPEN.
- No handshake; one input sample consumed every sample_clock edge.

## Structure
- Shared package envelope_pkg: gate_state_t enum (3 bits, values above), GAIN_UNITY function/localparam of GAIN_WIDTH.
- Sub-module gain_apply: signed x unsigned multiply, shift, output register; envelope_gate holds FSM, ramp and hold counter.

## Test plan
- Reset: drive audio_in=24'h100000, env_in=max with rst high -> audio_out=0, gain=0, state=CLOSED; after release, ATTACK next edge.
- Attack ramp: GAIN_WIDTH=16, attack_step=16384, env_in above -> gain 16384, 32768, 49152, 65536; OPEN on 4th ATTACK edge; audio_in=1000 gives audio_out=1000 one sample after gain=65536.
- Hold/release: hold_len=3, env_in drops below close_thresh in OPEN -> exactly 3 cycles HOLD, then RELEASE with release_step=32768 -> gain 32768, 0, CLOSED; gate_open low from RELEASE entry.
- Retrigger: env above during HOLD cycle 2 -> OPEN next edge, gain stays 65536; env above during RELEASE at gain 32768 -> ATTACK, ramp resumes from 32768.
- Hysteresis: open_thresh=1000, close_thresh=500, env=700 in OPEN -> stays OPEN; env=700 in CLOSED -> stays CLOSED.
- Edge cases: attack_step=0 -> CLOSED->ATTACK->OPEN with gain UNITY in one ATTACK edge; hold_len=0 -> OPEN->RELEASE directly; audio_in=-1 at gain 32768 -> audio_out=-1.
